// File: rtl/calc_seq_ctrl_if.sv
// Keypad, ALU handshake and display bundle for calc_seq_ctrl.
// The controller uses the slave modport; the environment (keypad, ALU, display) uses master.
interface calc_seq_ctrl_if #(
  parameter int W = 14
);
  logic             btn_press;
  logic             is_num;
  logic             is_op;
  logic             is_eq;
  logic [3:0]       num_val;
  logic [1:0]       op_val;
  logic             alu_start;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [1:0]       alu_op;
  logic             alu_done;
  logic [2*W-1:0]   alu_result;
  logic [2*W-1:0]   disp_val;
  logic [1:0]       disp_sel;
  logic             busy;
  logic             err;

  modport slave (
    input  btn_press, is_num, is_op, is_eq, num_val, op_val, alu_done, alu_result,
    output alu_start, alu_a, alu_b, alu_op, disp_val, disp_sel, busy, err
  );

  modport master (
    output btn_press, is_num, is_op, is_eq, num_val, op_val, alu_done, alu_result,
    input  alu_start, alu_a, alu_b, alu_op, disp_val, disp_sel, busy, err
  );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: keypad events -> operand A, operator, operand B -> ALU launch -> result display.
// Optional ALU watchdog enabled by defining CALC_ALU_TIMEOUT_EN.
//
// state   | meaning
// A_ENTRY | accumulating operand A, waiting for an operator
// B_ENTRY | accumulating operand B, waiting for "="
// EXEC    | ALU launched, waiting for alu_done (keys dropped)
// RESULT  | result held for display until the next digit
module calc_seq_ctrl #(
  parameter int DIGITS  = 4,
  parameter int W       = 14,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  calc_seq_ctrl_if.slave bus
);

  localparam int            DW   = $clog2(DIGITS + 1);
  localparam logic [DW-1:0] DMAX = DW'(DIGITS);
  localparam logic [W-1:0]  TEN  = W'(10);

  // Elaboration-time sanity check on the parameter set.
  if ((TIMEOUT < 1) || ((10 ** DIGITS) - 1 >= (2 ** W))) begin : g_bad_cfg
    $error("calc_seq_ctrl: W cannot hold DIGITS decimal digits, or TIMEOUT < 1");
  end

  typedef enum logic [1:0] {
    A_ENTRY = 2'd0,
    B_ENTRY = 2'd1,
    EXEC    = 2'd2,
    RESULT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             btn_q;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [DW-1:0]    na_q, na_d;
  logic [DW-1:0]    nb_q, nb_d;
  logic [1:0]       op_q, op_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             start_q, start_d;
  logic             key_ev;
  logic             op_ok;
  logic [1:0]       sel;

`ifdef CALC_ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             err_q, err_d;
`endif

  assign key_ev = bus.btn_press & ~btn_q;
  assign op_ok  = (bus.op_val == 2'd1) || (bus.op_val == 2'd2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= A_ENTRY;
      btn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      na_q    <= '0;
      nb_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
      start_q <= 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      btn_q   <= bus.btn_press;
      a_q     <= a_d;
      b_q     <= b_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      op_q    <= op_d;
      res_q   <= res_d;
      start_q <= start_d;
`ifdef CALC_ALU_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    na_d    = na_q;
    nb_d    = nb_q;
    op_d    = op_q;
    res_d   = res_q;
    start_d = 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
    tmr_d   = tmr_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      A_ENTRY: begin
        if (key_ev) begin
          if (bus.is_num && (na_q != DMAX)) begin
            a_d  = a_q * TEN + W'(bus.num_val);
            na_d = na_q + DW'(1);
          end else if (bus.is_op && op_ok) begin
            op_d    = bus.op_val;
            b_d     = '0;
            nb_d    = '0;
            state_d = B_ENTRY;
          end
        end
      end

      B_ENTRY: begin
        if (key_ev) begin
          if (bus.is_num && (nb_q != DMAX)) begin
            b_d  = b_q * TEN + W'(bus.num_val);
            nb_d = nb_q + DW'(1);
          end else if (bus.is_op && op_ok && (nb_q == '0)) begin
            op_d = bus.op_val;
          end else if (bus.is_eq && (nb_q != '0)) begin
            start_d = 1'b1;
            state_d = EXEC;
`ifdef CALC_ALU_TIMEOUT_EN
            tmr_d   = TW'(TIMEOUT - 1);
`endif
          end
        end
      end

      EXEC: begin
        if (bus.alu_done) begin
          res_d   = bus.alu_result;
          state_d = RESULT;
`ifdef CALC_ALU_TIMEOUT_EN
        end else if (tmr_q == '0) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESULT;
        end else begin
          tmr_d   = tmr_q - TW'(1);
`endif
        end
      end

      RESULT: begin
        // A digit starts a fresh calculation with that digit as A.
        if (key_ev && bus.is_num) begin
          a_d     = W'(bus.num_val);
          na_d    = DW'(1);
          b_d     = '0;
          nb_d    = '0;
          op_d    = '0;
`ifdef CALC_ALU_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = A_ENTRY;
        end
      end

      default: state_d = A_ENTRY;
    endcase
  end

  always_comb begin
    sel = 2'd0;
    unique case (state_q)
      A_ENTRY: sel = 2'd0;
      B_ENTRY: sel = (nb_q != '0) ? 2'd1 : 2'd0;
      EXEC:    sel = 2'd1;
      RESULT:  sel = 2'd2;
      default: sel = 2'd0;
    endcase
  end

  always_comb begin
    bus.disp_val = {{W{1'b0}}, a_q};
    if (sel == 2'd1) begin
      bus.disp_val = {{W{1'b0}}, b_q};
    end else if (sel == 2'd2) begin
      bus.disp_val = res_q;
    end
  end

  assign bus.disp_sel  = sel;
  assign bus.alu_start = start_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.busy      = (state_q == EXEC);

`ifdef CALC_ALU_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
